serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder. Captures two operands plus carry-in, then feeds one bit pair per clock, LSB first, through a single full_adder cell.
- A registered carry links the bits. The result is presented behind a valid/ready handshake.
- Sits upstream of the full_adder cell as its sequencing/feed stage. Used where area matters more than latency (e.g. accumulators in slow control paths).

---
 rtl/serial_arith_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// counter sizing.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      SPARE = 2'd3
   } state_t;

   // Width of a counter that must index 0..w-1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 32'd1) ? $unsigned($clog2(w)) : 32'd1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, used as the bit slice of the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are captured, then fed LSB first through one
// full_adder cell with a registered carry; the result is offered on a valid/ready handshake.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             msb_cin_q, msb_cin_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             fa_s, fa_co;

   full_adder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_co)
   );

   // The unused encoding behaves exactly like IDLE.
   assign in_ready  = (state_q == IDLE) || (state_q == SPARE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      sum_sh_d  = sum_sh_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      msb_cin_d = msb_cin_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      unique case (state_q)
         RUN: begin
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_co;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 2)) begin
               msb_cin_d = fa_co;
            end
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
               sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
               cout_d  = fa_co;
               ovf_d   = msb_cin_q ^ fa_co;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            if (in_valid) begin
               a_sh_d   = a;
               b_sh_d   = b;
               carry_d  = cin;
               cnt_d    = '0;
               sum_sh_d = '0;
               state_d  = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         sum_sh_q  <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         msb_cin_q <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         sum_sh_q  <= sum_sh_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         msb_cin_q <= msb_cin_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit instance for directed/random/handshake cases and a
// 4-bit instance swept over every operand combination, both checked against arithmetic.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, sum;
   logic       cin, cout, ovf;
   logic       v4, rdy4, ov4, or4, c4, co4, of4;
   logic [3:0] a4, b4, s4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v4),
      .in_ready  (rdy4),
      .a         (a4),
      .b         (b4),
      .cin       (c4),
      .out_valid (ov4),
      .out_ready (or4),
      .sum       (s4),
      .cout      (co4),
      .ovf       (of4)
   );

   // Reference: {ovf, cout, sum} of a w-bit add, from plain integer arithmetic and sign rules.
   function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic c);
      logic [32:0] full;
      logic [31:0] s;
      logic        co, ov;
      full = {1'b0, x} + {1'b0, y} + 33'(c);
      s    = full[31:0] & ((32'h1 << w) - 32'h1);
      co   = full[w];
      ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
      return {ov, co, s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation; bp > 0 holds out_ready low for bp cycles while poking in_valid.
   task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input int bp);
      logic [33:0] e;
      int          lat;
      e = model(8, {24'b0, x}, {24'b0, y}, c);
      @(negedge clk);
      chk("ready_idle", in_ready, 1);
      in_valid = 1'b1; a = x; b = y; cin = c;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("latency", lat, 8);
      chk("sum", sum, e[7:0]);
      chk("cout", cout, e[32]);
      chk("ovf", ovf, e[33]);
      if (bp > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < bp; i++) begin
            in_valid = ~i[0]; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_sum", sum, e[7:0]);
            chk("bp_cout", cout, e[32]);
            chk("bp_ovf", ovf, e[33]);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("handoff_ready", in_ready, 1);
      chk("handoff_valid", out_valid, 0);
   endtask

   task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c);
      logic [33:0] e;
      int          lat;
      e = model(4, {28'b0, x}, {28'b0, y}, c);
      @(negedge clk);
      v4 = 1'b1; a4 = x; b4 = y; c4 = c;
      @(posedge clk);
      @(negedge clk);
      v4 = 1'b0;
      lat = 0;
      while (ov4 !== 1'b1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("w4_sum", s4, e[3:0]);
      chk("w4_cout", co4, e[32]);
      chk("w4_ovf", of4, e[33]);
      @(posedge clk);
   endtask

   initial begin
      logic [7:0]  ba[3], bb[3];
      logic        bc[3];
      int          acc_cyc[3];
      logic [33:0] expq[$];
      logic [33:0] e;
      int          cyc, nacc, nres, spur;
      logic        took;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      v4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; c4 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst4_in_ready", rdy4, 1);
      chk("rst4_out_valid", ov4, 0);
      rst_n = 1'b1;

      op8(8'h5A, 8'h3C, 1'b0, 0);
      op8(8'hFF, 8'h01, 1'b0, 0);
      op8(8'h7F, 8'h00, 1'b1, 0);
      op8(8'h80, 8'h80, 1'b1, 5);
      for (int i = 0; i < 12; i++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom), 0);
      end

      // Back-to-back with in_valid and out_ready held high.
      for (int i = 0; i < 3; i++) begin
         ba[i] = 8'($urandom); bb[i] = 8'($urandom); bc[i] = 1'($urandom);
      end
      @(negedge clk);
      a = ba[0]; b = bb[0]; cin = bc[0]; in_valid = 1'b1; out_ready = 1'b1;
      cyc = 0; nacc = 0; nres = 0;
      while (nres < 3 && cyc < 100) begin
         took = (in_ready === 1'b1) && (nacc < 3);
         if (took) begin
            acc_cyc[nacc] = cyc;
            expq.push_back(model(8, {24'b0, ba[nacc]}, {24'b0, bb[nacc]}, bc[nacc]));
         end
         if (out_valid === 1'b1) begin
            if (expq.size() == 0) begin
               chk("b2b_spurious", out_valid, 0);
            end else begin
               e = expq.pop_front();
               chk("b2b_sum", sum, e[7:0]);
               chk("b2b_cout", cout, e[32]);
               chk("b2b_ovf", ovf, e[33]);
            end
            nres++;
         end
         @(posedge clk);
         cyc++;
         #1;
         if (took) begin
            nacc++;
            if (nacc < 3) begin
               a = ba[nacc]; b = bb[nacc]; cin = bc[nacc];
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      chk("b2b_results", nres, 3);
      chk("b2b_space01", acc_cyc[1] - acc_cyc[0], 10);
      chk("b2b_space12", acc_cyc[2] - acc_cyc[1], 10);
      in_valid = 1'b0;
      repeat (12) @(posedge clk);

      // Reset in the middle of RUN (cnt == 3), with a nonzero prior result on the outputs.
      op8(8'h12, 8'h34, 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b1; a = 8'hC3; b = 8'h5D; cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      chk("mid_rst_ovf", ovf, 0);
      spur = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) spur++;
      end
      chk("mid_rst_no_valid", spur, 0);
      op8(8'($urandom), 8'($urandom), 1'($urandom), 0);

      for (int i = 0; i < 512; i++) begin
         op4(i[3:0], i[7:4], i[8]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
